mux4_word_sequencer: RTL and testbench
======================================

# mux4_word_sequencer

Upstream sequencer for the 4:1 mux built from 2:1 muxes. It accepts 4-bit words over a valid/ready handshake and drives the mux `datain` and `s` inputs. It steps the select through 0,1,2,3 and samples the mux output `y` once per beat. The result is a serial bit stream with bit-valid and last-bit flags, one bit per beat, LSB (select 0) first.

## Interface
Parameters:
- `BIT_HOLD`, default 1: number of clock cycles each select value is held before `y` is sampled. Legal range is 1..8; the internal hold counter is 3 bits wide.

Ports:
- `clk`, input, 1: rising-edge clock. This is the only clock.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: upstream word valid.
- `in_data`, input, 4: upstream word.
- `in_ready`, output, 1: block can accept a word this cycle. Combinational from state and counters.
- `datain`, output, 4: registered word driven to the mux `datain`.
- `s`, output, 2: registered select driven to the mux `s`.
- `y`, input, 1: mux output. It is `datain[s]`, combinational through the mux.
- `bit_out`, output, 1: registered sample of `y`.
- `bit_valid`, output, 1: one-cycle strobe; `bit_out` is valid.
- `bit_last`, output, 1: asserted with `bit_valid` on the select-3 bit.
- `busy`, output, 1: high while in SHIFT.

## Operation
States:
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `datain` <= `in_data`, `s` <= 0, `hold_cnt` <= 0, go to SHIFT.
  - Otherwise `s` holds 0 and `datain` retains the last word.
- SHIFT: `hold_cnt` increments each cycle. The final cycle of a beat is `hold_cnt == BIT_HOLD-1`. In that cycle:
  - `bit_out` <= `y`, `bit_valid` <= 1, `bit_last` <= (`s`==3).
  - If `s` < 3: `s` <= `s`+1, `hold_cnt` <= 0.
  - If `s` == 3 and `in_valid`=1: back-to-back accept. Load the new word, `s` <= 0, `hold_cnt` <= 0, stay in SHIFT.
  - If `s` == 3 and `in_valid`=0: go to IDLE, `s` <= 0.
- `in_ready` = IDLE, or (SHIFT and `s`==3 and `hold_cnt`==`BIT_HOLD-1`).
- `in_valid` while `in_ready`=0 is ignored. `in_data` is not captured; upstream holds the word until accepted.
- `bit_valid` and `bit_last` are low in every cycle other than the one following a final beat cycle.
- `y` is treated as combinational from the registered `datain`/`s`. The block never samples `y` in the cycle a new word or select is loaded.

Reset values, applied on the next edge after `rst`=1:
- state IDLE, `hold_cnt`=0.
- `datain`=4'b0000, `s`=2'b00.
- `bit_out`=0, `bit_valid`=0, `bit_last`=0.
- `busy`=0, so `in_ready`=1 in the first cycle after reset.

Boundary conditions:
- Reset mid-word aborts the word. No further `bit_valid` is produced for it, and the partial word is discarded.
- `rst` has priority over a simultaneous accept: the word is dropped and `in_ready` must not be treated as a completed handshake.
- `BIT_HOLD`=1 makes every SHIFT cycle a final beat cycle.

## Timing
- Accept at edge E0.
- `datain`/`s`=0 are valid from E0 to E0+`BIT_HOLD`.
- Bit k is sampled at edge E0+(k+1)·`BIT_HOLD` and is visible on `bit_out` in the following cycle.
- First-bit latency from the accept edge is `BIT_HOLD` cycles.
- Word duration is 4·`BIT_HOLD` cycles.
- Sustained throughput with continuous `in_valid` is one word per 4·`BIT_HOLD` cycles, with no idle cycle between words.
- `bit_valid` runs contiguously every cycle for `BIT_HOLD`=1 and back-to-back words.
- Each select value is stable for exactly `BIT_HOLD` cycles; `s` never skips or repeats within a word.

## Test plan
- Reset, then idle: `rst`=1 for 2 cycles → `datain`=0, `s`=0, `bit_valid`=0, `bit_last`=0, `busy`=0, `in_ready`=1.
- Single word, `BIT_HOLD`=1, `in_data`=4'b0011 → `s` steps 0,1,2,3 on consecutive cycles; `bit_out`=1,1,0,0 with `bit_valid` for 4 cycles; `bit_last` only on the 4th; then IDLE.
- Back-to-back words, `BIT_HOLD`=1: 4'b0011 then 4'b1101 with `in_valid` held → 8 contiguous bits 1,1,0,0,1,0,1,1; `in_ready` high only on the s=3 cycles; no gap between words.
- `BIT_HOLD`=3, `in_data`=4'b1101 → each `s` value held 3 cycles; `bit_valid` every 3rd cycle carrying 1,0,1,1; word spans 12 cycles.
- Backpressure: `in_valid` with 4'b0110 asserted at s=1 of a word in progress → not accepted until the s=3 final cycle; the in-progress word's bits are unaffected; 4'b0110 then serializes as 0,1,1,0.
- Reset mid-word: assert `rst` at s=2 of 4'b1101 → next cycle all outputs at reset values, no further `bit_valid`; a fresh 4'b0011 after reset yields 1,1,0,0.

Source files
------------

// File: rtl/mux4_word_sequencer_if.sv
// Handshake and mux-side signals for the 4:1 mux word sequencer.
// The sequencer takes the slave view; the upstream/mux side takes the master view.
interface mux4_word_sequencer_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] datain;
    logic [1:0] s;
    logic       y;
    logic       bit_out;
    logic       bit_valid;
    logic       bit_last;
    logic       busy;

    modport slave (
        input  in_valid, in_data, y,
        output in_ready, datain, s, bit_out, bit_valid, bit_last, busy
    );

    modport master (
        output in_valid, in_data, y,
        input  in_ready, datain, s, bit_out, bit_valid, bit_last, busy
    );
endinterface

// File: rtl/mux4_word_sequencer.sv
// Serialises 4-bit words through an external 4:1 mux: steps s 0..3, holds each
// select for BIT_HOLD cycles and samples y on the last cycle of every beat.
module mux4_word_sequencer #(
    parameter int BIT_HOLD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_word_sequencer_if.slave bus
);
    localparam logic [2:0] HOLD_LAST = 3'(BIT_HOLD - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state, state_next;
    logic [2:0] hold_cnt, hold_next;
    logic [3:0] datain, datain_next;
    logic [1:0] s, s_next;
    logic       bit_out, bit_out_next;
    logic       bit_valid, bit_valid_next;
    logic       bit_last, bit_last_next;
    logic       in_ready;
    logic       final_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= 3'd0;
            datain    <= 4'b0000;
            s         <= 2'b00;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_last  <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            datain    <= datain_next;
            s         <= s_next;
            bit_out   <= bit_out_next;
            bit_valid <= bit_valid_next;
            bit_last  <= bit_last_next;
        end
    end

    assign final_beat = (state == SHIFT) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next     = state;
        hold_next      = hold_cnt;
        datain_next    = datain;
        s_next         = s;
        bit_out_next   = bit_out;
        bit_valid_next = 1'b0;
        bit_last_next  = 1'b0;
        in_ready       = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                s_next   = 2'b00;
                if (bus.in_valid) begin
                    datain_next = bus.in_data;
                    hold_next   = 3'd0;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                hold_next = hold_cnt + 3'd1;
                if (final_beat) begin
                    // y is stable here: datain/s were loaded at least one edge ago
                    bit_out_next   = bus.y;
                    bit_valid_next = 1'b1;
                    bit_last_next  = (s == 2'd3);
                    hold_next      = 3'd0;
                    if (s != 2'd3) begin
                        s_next = s + 2'd1;
                    end else begin
                        in_ready = 1'b1;
                        s_next   = 2'b00;
                        if (bus.in_valid) begin
                            datain_next = bus.in_data;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready;
    assign bus.datain    = datain;
    assign bus.s         = s;
    assign bus.bit_out   = bit_out;
    assign bus.bit_valid = bit_valid;
    assign bus.bit_last  = bit_last;
    assign bus.busy      = (state == SHIFT);
endmodule

// File: tb/tb_mux4_word_sequencer.sv
// Bench for mux4_word_sequencer: one instance with BIT_HOLD=1, one with BIT_HOLD=3,
// each checked every cycle against a timeline model plus literal bit-stream expectations.
module tb_mux4_word_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux4_word_sequencer_if bus0();
    mux4_word_sequencer_if bus1();

    logic       v[2];
    logic [3:0] d[2];
    logic       rdy[2], bv[2], bl[2], bo[2], bsy[2];
    logic [3:0] dq[2];
    logic [1:0] sq[2];

    assign bus0.in_valid = v[0];
    assign bus0.in_data  = d[0];
    assign bus0.y        = bus0.datain[bus0.s];
    assign bus1.in_valid = v[1];
    assign bus1.in_data  = d[1];
    assign bus1.y        = bus1.datain[bus1.s];

    assign rdy[0] = bus0.in_ready;  assign rdy[1] = bus1.in_ready;
    assign bv[0]  = bus0.bit_valid; assign bv[1]  = bus1.bit_valid;
    assign bl[0]  = bus0.bit_last;  assign bl[1]  = bus1.bit_last;
    assign bo[0]  = bus0.bit_out;   assign bo[1]  = bus1.bit_out;
    assign bsy[0] = bus0.busy;      assign bsy[1] = bus1.busy;
    assign dq[0]  = bus0.datain;    assign dq[1]  = bus1.datain;
    assign sq[0]  = bus0.s;         assign sq[1]  = bus1.s;

    mux4_word_sequencer #(.BIT_HOLD(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    mux4_word_sequencer #(.BIT_HOLD(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    function automatic int hold_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
    endtask

    // Timeline model: a word accepted at an edge occupies 4*H cycles; bit k is
    // sampled when (t+1) reaches (k+1)*H, where t counts cycles since accept.
    logic       m_busy[2] = '{1'b0, 1'b0};
    int         m_t[2]    = '{0, 0};
    logic [3:0] m_word[2] = '{4'h0, 4'h0};
    logic       m_bv[2]   = '{1'b0, 1'b0};
    logic       m_bl[2]   = '{1'b0, 1'b0};
    logic       m_bo[2]   = '{1'b0, 1'b0};

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int h;
            logic ready;
            h = hold_of(i);
            if (rst) begin
                m_busy[i] = 1'b0; m_t[i] = 0; m_word[i] = 4'h0;
                m_bv[i] = 1'b0; m_bl[i] = 1'b0; m_bo[i] = 1'b0;
            end else begin
                ready = !m_busy[i] || (m_t[i] == 4*h - 1);
                if (m_busy[i] && ((m_t[i] + 1) % h == 0)) begin
                    int k;
                    k = (m_t[i] + 1) / h - 1;
                    m_bo[i] = m_word[i][k];
                    m_bv[i] = 1'b1;
                    m_bl[i] = (k == 3);
                end else begin
                    m_bv[i] = 1'b0;
                    m_bl[i] = 1'b0;
                end
                if (m_busy[i]) begin
                    m_t[i]++;
                    if (m_t[i] == 4*h) begin
                        m_busy[i] = 1'b0;
                        m_t[i] = 0;
                    end
                end
                if (ready && v[i]) begin
                    m_word[i] = d[i];
                    m_busy[i] = 1'b1;
                    m_t[i] = 0;
                end
            end
        end
    end

    typedef struct {
        int   u;
        logic b;
        logic l;
        int   c;
    } cap_t;
    cap_t cap[$];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (chk_en) begin
                int h;
                h = hold_of(i);
                check($sformatf("u%0d datain", i), dq[i], m_word[i]);
                check($sformatf("u%0d s", i), sq[i], m_busy[i] ? m_t[i] / h : 0);
                check($sformatf("u%0d busy", i), bsy[i], m_busy[i]);
                check($sformatf("u%0d in_ready", i), rdy[i], !m_busy[i] || (m_t[i] == 4*h - 1));
                check($sformatf("u%0d bit_valid", i), bv[i], m_bv[i]);
                check($sformatf("u%0d bit_last", i), bl[i], m_bl[i]);
                check($sformatf("u%0d bit_out", i), bo[i], m_bo[i]);
            end
            if (bv[i] === 1'b1) cap.push_back('{i, bo[i], bl[i], cyc});
        end
    end

    task automatic send(int i, logic [3:0] w);
        v[i] = 1'b1;
        d[i] = w;
        for (int c = 0; c < 200; c++) begin
            if (rdy[i] === 1'b1) begin
                @(negedge clk);
                v[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        v[i] = 1'b0;
        timeout_fail($sformatf("u%0d send", i));
    endtask

    task automatic wait_s(int i, logic [1:0] sv);
        for (int c = 0; c < 200; c++) begin
            if (bsy[i] === 1'b1 && sq[i] === sv) return;
            @(negedge clk);
        end
        timeout_fail($sformatf("u%0d wait_s", i));
    endtask

    task automatic wait_idle(int i);
        for (int c = 0; c < 200; c++) begin
            if (bsy[i] === 1'b0) begin
                @(negedge clk);
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        timeout_fail($sformatf("u%0d wait_idle", i));
    endtask

    // bits[k]/lasts[k] are the k-th expected serial bit and last flag.
    task automatic expect_stream(string tag, int i, int n, logic [7:0] bits,
                                 logic [7:0] lasts, int span);
        cap_t got[$];
        foreach (cap[j]) if (cap[j].u == i) got.push_back(cap[j]);
        check({tag, " count"}, got.size(), n);
        for (int k = 0; k < n && k < got.size(); k++) begin
            check($sformatf("%s bit%0d", tag, k), got[k].b, bits[k]);
            check($sformatf("%s last%0d", tag, k), got[k].l, lasts[k]);
        end
        if (got.size() > 1) check({tag, " span"}, got[got.size()-1].c - got[0].c, span);
        cap.delete();
    endtask

    task automatic expect_reset_outputs(string tag, int i);
        check({tag, " datain"}, dq[i], 4'b0000);
        check({tag, " s"}, sq[i], 2'b00);
        check({tag, " bit_valid"}, bv[i], 1'b0);
        check({tag, " bit_last"}, bl[i], 1'b0);
        check({tag, " busy"}, bsy[i], 1'b0);
        check({tag, " in_ready"}, rdy[i], 1'b1);
    endtask

    initial begin
        v[0] = 1'b0; v[1] = 1'b0;
        d[0] = 4'h0; d[1] = 4'h0;
        rst  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        expect_reset_outputs("rst u0", 0);
        expect_reset_outputs("rst u1", 1);
        cap.delete();

        // Single word, BIT_HOLD=1: 0011 -> 1,1,0,0
        send(0, 4'b0011);
        wait_idle(0);
        expect_stream("single", 0, 4, 8'b0000_0011, 8'b0000_1000, 3);

        // Back-to-back, BIT_HOLD=1: 8 contiguous bits 1,1,0,0,1,0,1,1
        send(0, 4'b0011);
        send(0, 4'b1101);
        wait_idle(0);
        expect_stream("b2b", 0, 8, 8'b1101_0011, 8'b1000_1000, 7);

        // BIT_HOLD=3: 1101 -> 1,0,1,1 every third cycle
        send(1, 4'b1101);
        wait_idle(1);
        expect_stream("hold3", 1, 4, 8'b0000_1101, 8'b0000_1000, 9);

        // Backpressure: 0110 offered at s=1, accepted only at the s=3 final cycle
        send(1, 4'b1101);
        wait_s(1, 2'd1);
        send(1, 4'b0110);
        wait_idle(1);
        expect_stream("bpress", 1, 8, 8'b0110_1101, 8'b1000_1000, 21);

        // Reset mid-word at s=2 aborts the word
        send(0, 4'b1101);
        wait_s(0, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_reset_outputs("midrst", 0);
        repeat (3) @(negedge clk);
        check("midrst no bit", bv[0], 1'b0);
        cap.delete();
        send(0, 4'b0011);
        wait_idle(0);
        expect_stream("after rst", 0, 4, 8'b0000_0011, 8'b0000_1000, 3);

        // Reset wins over a simultaneous accept
        v[0] = 1'b1;
        d[0] = 4'b1111;
        rst  = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        v[0] = 1'b0;
        expect_reset_outputs("rst prio", 0);
        repeat (4) @(negedge clk);
        check("rst prio no bits", cap.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
